// File: rtl/icache_if.sv
// Fetch-side and memory-side bundles for the direct-mapped icache.
// Fetch: master = fetch stage, slave = cache. Mem: master = cache, slave = mem ctrl.
interface icache_fetch_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_valid;
  logic [31:0] if_instr;

  modport master (
    output if_req, if_addr, if_flush,
    input  if_valid, if_instr
  );
  modport slave (
    input  if_req, if_addr, if_flush,
    output if_valid, if_instr
  );
endinterface

interface icache_mem_if;
  logic        mem_req_en;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_instr;

  modport master (
    output mem_req_en, mem_req_addr,
    input  mem_resp_valid, mem_resp_instr
  );
  modport slave (
    input  mem_req_en, mem_req_addr,
    output mem_resp_valid, mem_resp_instr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Single-cycle hits; misses fetch one word, fill, and forward it.
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  icache_fetch_if.slave fetch,
  icache_mem_if.master  mem
);
  localparam int TAG_BITS = 32 - INDEX_BITS - 2;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    MISS,
    ABORT
  } state_t;

  state_t                r_state;
  logic [LINES-1:0]      r_valid;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [31:0]           r_data [LINES];
  logic [29:0]           r_addr;
  logic                  r_if_valid;
  logic [31:0]           r_if_instr;
  logic                  r_mem_en;
  logic [31:0]           r_mem_addr;

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic                  w_hit;
  logic [INDEX_BITS-1:0] w_fill_idx;
  logic [TAG_BITS-1:0]   w_fill_tag;
  logic                  w_fill;
  logic                  w_unused_addr;

  assign w_idx      = fetch.if_addr[INDEX_BITS+1:2];
  assign w_tag      = fetch.if_addr[31:INDEX_BITS+2];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_fill_idx = r_addr[INDEX_BITS-1:0];
  assign w_fill_tag = r_addr[29:INDEX_BITS];
  assign w_unused_addr = &{1'b0, fetch.if_addr[1:0]};

  // A fill happens only when the response is not cancelled by a flush.
  assign w_fill = rdy && (r_state == MISS) &&
                  mem.mem_resp_valid && !fetch.if_flush;

  assign fetch.if_valid = r_if_valid;
  assign fetch.if_instr = r_if_instr;
  assign mem.mem_req_en   = r_mem_en;
  assign mem.mem_req_addr = r_mem_addr;

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= mem.mem_resp_instr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_valid    <= '0;
      r_addr     <= '0;
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_mem_en   <= 1'b0;
      r_mem_addr <= '0;
    end else if (rdy) begin
      r_if_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (fetch.if_flush) begin
            r_valid <= '0;
          end else if (fetch.if_req) begin
            if (w_hit) begin
              r_if_valid <= 1'b1;
              r_if_instr <= r_data[w_idx];
            end else begin
              r_mem_en   <= 1'b1;
              r_mem_addr <= {fetch.if_addr[31:2], 2'b00};
              r_addr     <= fetch.if_addr[31:2];
              r_state    <= MISS;
            end
          end
        end
        MISS: begin
          if (mem.mem_resp_valid) begin
            r_mem_en <= 1'b0;
            r_state  <= IDLE;
            if (fetch.if_flush) begin
              r_valid <= '0;
            end else begin
              r_valid[w_fill_idx] <= 1'b1;
              r_if_valid <= 1'b1;
              r_if_instr <= mem.mem_resp_instr;
            end
          end else if (fetch.if_flush) begin
            // Controller fetch is in flight; keep the request up and drain it.
            r_valid <= '0;
            r_state <= ABORT;
          end
        end
        ABORT: begin
          if (fetch.if_flush) begin
            r_valid <= '0;
          end
          if (mem.mem_resp_valid) begin
            r_mem_en <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule
